mc_alu_unit: RTL and testbench
==============================

// Module: mc_alu_unit
// PURPOSE
//  Parametrised multi-cycle ALU for the multi-cycle MIPS datapath, sitting between the register file/imm mux and
//  the write-back mux. Executes logic, arith, compare and shift ops in 1 cycle and iterative shift-add
//  multiply (signed/unsigned, 2*WIDTH product) in WIDTH cycles, with valid/ready handshakes on both sides.
//  Provides registered zero/carry/overflow flags for branch resolution by the control FSM.
// PARAMETERS
//  WIDTH    32   operand/result width; power of two, >= 8
//  SHAMT_W  $clog2(WIDTH)  localparam, shift-amount bits taken from b
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  Reset      in   1       reset, synchronous, active-low
//  in_valid   in   1       operands/op valid
//  in_ready   out  1       unit can accept (state IDLE)
//  op         in   4       opcode (encoding below)
//  a          in   WIDTH   operand A (rs)
//  b          in   WIDTH   operand B (rt or sign-extended imm)
//  out_valid  out  1       result/flags valid (state DONE)
//  out_ready  in   1       consumer accepts result
//  result_lo  out  WIDTH   result / product low half
//  result_hi  out  WIDTH   product high half; 0 for non-multiply ops
//  zero       out  1       result_lo == 0 (MUL: {hi,lo} == 0)
//  carry      out  1       ADD: carry-out; SUB: borrow (a <u b); else 0
//  ovf        out  1       signed overflow for ADD/SUB; else 0
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 NAND, 6 XOR, 7 SLT (signed), 8 SLTU, 9 SLL, 10 SRL,
//   11 SRA (shift a by b[SHAMT_W-1:0]), 12 MULU, 13 MUL (signed), 14-15 reserved -> result 0, flags 0, 1-cycle.
//  Reset (Reset==0 at posedge): state IDLE, out_valid 0, result_lo/hi 0, zero/carry/ovf 0, counter 0;
//   takes priority over everything, aborts any in-flight multiply, no result emitted.
//  FSM IDLE/MUL/DONE. in_ready = (state==IDLE); accept = in_valid & in_ready.
//  IDLE: on accept of non-multiply op, result+flags registered, -> DONE (out_valid 1 cycle after accept).
//   On MULU/MUL: latch |a|,|b| (signed op: magnitudes, sign = a[W-1]^b[W-1]), clear acc, cnt=0, -> MUL.
//   No accept: stay IDLE, outputs hold last values.
//  MUL: each cycle add multiplicand if multiplier LSB, shift {acc,mplier} right 1, cnt++;
//   after WIDTH iterations (cnt==WIDTH-1) write {hi,lo}, negating 2*WIDTH product if sign set, -> DONE.
//   out_valid rises exactly WIDTH+1 cycles after accept. in_valid ignored while MUL.
//  DONE: out_valid=1; result/flags held stable while out_ready==0 (unbounded backpressure).
//   out_valid & out_ready -> IDLE next cycle; no new accept in the same cycle (min issue interval 2).
//  Arithmetic: ADD/SUB use WIDTH+1-bit sum; ovf = operand signs equal (ADD) / differ (SUB) and result sign
//   differs from a. SLT/SLTU produce 0 or 1 in result_lo. Shifts >= WIDTH impossible (masked amount).
//  Flags computed from final registered result; valid only with out_valid.
// TESTING
//  T1 ADD a=FFFFFFFF b=00000001 -> lo=0, zero=1, carry=1, ovf=0, out_valid 1 cycle after accept.
//  T2 SUB a=7FFFFFFF b=FFFFFFFF -> lo=80000000, ovf=1, carry=1; SLT a=FFFFFFFF b=1 -> lo=1, SLTU -> lo=0.
//  T3 MULU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001, out_valid exactly 33 cycles after accept,
//   in_ready 0 throughout; MUL signed FFFFFFFD*00000005 -> hi=FFFFFFFF lo=FFFFFFF1.
//  T4 SRA a=80000000 b=00000024 -> lo=F8000000 (shift 4); SLL a=1 b=1F -> lo=80000000; op 14 -> lo=0.
//  T5 backpressure: out_ready=0 for 5 cycles after ADD result -> out_valid/lo/flags stable, in_ready 0;
//   out_ready=1 -> in_ready 1 next cycle, back-to-back ops every 2 cycles give correct results.
//  T6 Reset=0 at cycle 10 of a MULU -> next cycle busy 0, out_valid 0, outputs 0, in_ready 1; new ADD correct.

Source files
------------

// File: rtl/mc_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops and a WIDTH-cycle shift-add multiply.
// Valid/ready on both sides; the result and flags stay registered in DONE until the consumer takes them.
module mc_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state;

  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [SHAMT_W-1:0] cnt;
  logic               neg;

  logic [WIDTH:0]     add_sum, sub_dif, mul_sum;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_lo, a_mag, b_mag;
  logic               alu_c, alu_v, is_mul, is_signed;
  logic [2*WIDTH-1:0] prod, prod_fin;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_dif   = {1'b0, a} - {1'b0, b};
    shamt     = b[SHAMT_W-1:0];
    is_mul    = (op == OP_MULU) || (op == OP_MUL);
    is_signed = (op == OP_MUL);
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    alu_lo    = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op)
      OP_ADD: begin
        alu_lo = add_sum[WIDTH-1:0];
        alu_c  = add_sum[WIDTH];
        alu_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow.
        alu_lo = sub_dif[WIDTH-1:0];
        alu_c  = sub_dif[WIDTH];
        alu_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_lo = a & b;
      OP_OR:   alu_lo = a | b;
      OP_NOR:  alu_lo = ~(a | b);
      OP_NAND: alu_lo = ~(a & b);
      OP_XOR:  alu_lo = a ^ b;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_lo = a << shamt;
      OP_SRL:  alu_lo = a >> shamt;
      OP_SRA:  alu_lo = $signed(a) >>> shamt;
      default: alu_lo = '0;
    endcase
  end

  // One shift-add step; prod is the full product once the last step is taken.
  always_comb begin
    mul_sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    prod     = {mul_sum, mplier[WIDTH-1:1]};
    prod_fin = neg ? -prod : prod;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              mcand  <= a_mag;
              mplier <= b_mag;
              acc    <= '0;
              cnt    <= '0;
              neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              state  <= S_MUL;
            end else begin
              result_lo <= alu_lo;
              result_hi <= '0;
              zero      <= (alu_lo == '0);
              carry     <= alu_c;
              ovf       <= alu_v;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc    <= mul_sum[WIDTH:1];
          mplier <= {mul_sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH - 1)) begin
            result_lo <= prod_fin[WIDTH-1:0];
            result_hi <= prod_fin[2*WIDTH-1:WIDTH];
            zero      <= (prod_fin == '0);
            carry     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu_unit.sv
// Scoreboard bench for mc_alu_unit: directed corner cases plus random ops against a longint reference model.
module tb_mc_alu_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result_lo, result_hi;
  logic        zero, carry, ovf, busy;

  mc_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi),
    .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo, hi;
    logic        z, c, v;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  bit   rnd_bp = 0;
  bit   prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, r;
    logic [63:0] p;
    int          sh;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y % 32);
    e.lo = 0; e.hi = 0; e.c = 0; e.v = 0; e.lat = 1; e.acc_cyc = 0;
    case (o)
      4'd0: begin
        p = {32'b0, x} + {32'b0, y};
        e.lo = p[31:0]; e.c = p[32];
        r = sx + sy; e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        e.lo = x - y; e.c = (x < y);
        r = sx - sy; e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2: e.lo = x & y;
      4'd3: e.lo = x | y;
      4'd4: e.lo = ~(x | y);
      4'd5: e.lo = ~(x & y);
      4'd6: e.lo = x ^ y;
      4'd7: e.lo = (sx < sy) ? 1 : 0;
      4'd8: e.lo = (x < y) ? 1 : 0;
      4'd9: e.lo = x << sh;
      4'd10: e.lo = x >> sh;
      4'd11: begin r = sx >>> sh; p = r; e.lo = p[31:0]; end
      4'd12: begin p = {32'b0, x} * {32'b0, y}; e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
      4'd13: begin r = sx * sy; p = r; e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
      default: e.lo = 0;
    endcase
    e.z = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc_cyc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_result"}, {result_hi, result_lo}, 64'd0);
    chk({tag, "_flags"}, 64'({zero, carry, ovf}), 64'd0);
  endtask

  // Monitor: compares every cycle the result is presented, pops on handshake.
  always @(negedge clk) begin
    if (Reset && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        if (!prev_valid) chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
        chk("result_lo", 64'(result_lo), 64'(q[0].lo));
        chk("result_hi", 64'(result_hi), 64'(q[0].hi));
        chk("flags_zcv", 64'({zero, carry, ovf}), 64'({q[0].z, q[0].c, q[0].v}));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_valid = out_valid && !out_ready;
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, bad;
    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    Reset = 1'b1;

    // Single-cycle arithmetic and compare corners
    send(4'd0, 32'hFFFFFFFF, 32'h00000001);
    send(4'd1, 32'h7FFFFFFF, 32'hFFFFFFFF);
    send(4'd7, 32'hFFFFFFFF, 32'h00000001);
    send(4'd8, 32'hFFFFFFFF, 32'h00000001);
    drain();

    // Unsigned multiply: in_ready must stay low for all WIDTH iteration cycles
    send(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0; bad = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (in_ready || !busy) bad++;
      @(negedge clk);
      n++;
    end
    chk("mul_in_ready_low", 64'(bad), 64'd0);
    chk("mul_cycles", 64'(n), 64'd32);
    drain();
    send(4'd13, 32'hFFFFFFFD, 32'h00000005);
    send(4'd13, 32'h80000000, 32'h80000000);

    // Shifts and reserved opcode
    send(4'd11, 32'h80000000, 32'h00000024);
    send(4'd9, 32'h00000001, 32'h0000001F);
    send(4'd14, 32'h12345678, 32'h9ABCDEF0);
    drain();

    // Backpressure: result must hold for 5 stalled cycles
    out_ready = 1'b0;
    send(4'd0, 32'h00001234, 32'h00004321);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_valid_dropped", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 11)), rval(), rval());
    drain();

    // Reset in the middle of a multiply aborts it silently
    send(4'd12, 32'hDEADBEEF, 32'h12345679);
    repeat (9) @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1 q.delete();
    @(negedge clk);
    check_idle_reset("mul_abort");
    Reset = 1'b1;
    send(4'd0, 32'h00000005, 32'h00000007);
    drain();

    // Random ops with random consumer stalls
    rnd_bp = 1;
    for (int i = 0; i < 300; i++) send(4'($urandom_range(0, 15)), rval(), rval());
    drain();
    rnd_bp = 0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
